cypher_digit_reader: RTL and testbench

Upstream input stage of the cypher detector. Synchronises and debounces a raw keypad code and key-press level, then queues each accepted digit in a small FIFO. It presents the digits to the detector datapath/control as a one-cycle `read` strobe with a stable `digit`. It also aborts a stalled entry sequence with a timeout pulse.

---
 rtl/cypher_digit_reader.sv | 177 +++++++++++++++++
 tb/tb_cypher_digit_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cypher_digit_reader.sv
// rtl/cypher_digit_reader.sv - keypad sync/debounce, show-ahead digit FIFO and entry timeout
module cypher_digit_reader #(
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          key_down,
  input  logic                          accept,
  output logic                          read,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          seq_abort,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic               kd_s1_q, kd_s1_d, kd_q, kd_d;
  logic [DIGIT_W-1:0] kc_s1_q, kc_s1_d, kc_q, kc_d;
  state_t             state_q, state_d;
  logic [DCW-1:0]     cnt_q, cnt_d;
  logic [DIGIT_W-1:0] latch_q, latch_d;
  logic [DIGIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [DIGIT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               run_q, run_d;
  logic               push, wr_en, full;

  assign read       = (count_q != '0) && accept;
  assign digit      = mem_q[rd_ptr_q];
  assign seq_abort  = run_q && (timer_q == '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign full       = (count_q == CNT_FULL);

  always_comb begin
    kd_s1_d = key_down;
    kd_d    = kd_s1_q;
    kc_s1_d = key_code;
    kc_d    = kc_s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (kd_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
          latch_d = kc_q;
        end
      end
      PRESS_WAIT: begin
        if (!kd_q) begin
          state_d = IDLE;
        end else if (kc_q != latch_q) begin
          cnt_d   = '0;
          latch_d = kc_q;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          push    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!kd_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (kd_q) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An abort flushes the queue and swallows any push landing in the same cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = push && !seq_abort && (!full || read);
    if (seq_abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (read) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_en) begin
        mem_d[wr_ptr_q] = latch_q;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end else if (push) begin
        overflow_d = 1'b1;
      end
      count_d = count_q + CW'(wr_en) - CW'(read);
    end
  end

  always_comb begin
    timer_d = timer_q;
    run_d   = run_q;
    if (read) begin
      timer_d = TO_LOAD;
      run_d   = 1'b1;
    end else if (run_q) begin
      if (seq_abort) begin
        run_d = 1'b0;
      end else if (push) begin
        timer_d = TO_LOAD;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kd_s1_q    <= 1'b0;
      kd_q       <= 1'b0;
      kc_s1_q    <= '0;
      kc_q       <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      latch_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timer_q    <= '0;
      run_q      <= 1'b0;
    end else begin
      kd_s1_q    <= kd_s1_d;
      kd_q       <= kd_d;
      kc_s1_q    <= kc_s1_d;
      kc_q       <= kc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timer_q    <= timer_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: tb/tb_cypher_digit_reader.sv
// tb/tb_cypher_digit_reader.sv - directed bench for cypher_digit_reader
module tb_cypher_digit_reader;

  localparam int DW = 4;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] key_code;
  logic          key_down;
  logic          accept;
  logic          read;
  logic [DW-1:0] digit;
  logic          seq_abort;
  logic          overflow;
  logic [2:0]    fifo_count;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int base;
  logic [DW-1:0] last_digit = '0;

  cypher_digit_reader #(
    .DIGIT_W(DW), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .key_code(key_code), .key_down(key_down),
    .accept(accept), .read(read), .digit(digit), .seq_abort(seq_abort),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (read === 1'b1) begin
      rd_cnt     <= rd_cnt + 1;
      last_digit <= digit;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [DW-1:0] code);
    key_code = code;
    key_down = 1'b1;
    repeat (10) tick();
    key_down = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; key_code = '0; key_down = 1'b0; accept = 1'b1;
    repeat (3) tick();
    check("rst_read", read, 0);
    check("rst_digit", digit, 0);
    check("rst_abort", seq_abort, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    tick();

    // single press: read lands exactly 2+DB+1 edges after key_down rises
    key_code = 4'h7; key_down = 1'b1;
    repeat (6) tick();
    check("t1_early", read, 0);
    tick();
    check("t1_read", read, 1);
    check("t1_digit", digit, 4'h7);
    tick();
    check("t1_one_cycle", read, 0);
    check("t1_count", fifo_count, 0);
    repeat (6) tick();
    check("t1_abort_early", seq_abort, 0);
    tick();
    check("t1_abort", seq_abort, 1);
    tick();
    check("t1_abort_pulse", seq_abort, 0);
    repeat (5) tick();
    check("t1_held_once", rd_cnt, 1);
    key_down = 1'b0;
    repeat (10) tick();

    // queued digit flushed by timeout 8 cycles after the read
    accept = 1'b0;
    press(4'h9);
    press(4'hA);
    check("to_count2", fifo_count, 2);
    accept = 1'b1;
    #1;
    check("to_read", read, 1);
    check("to_digit", digit, 4'h9);
    tick();
    accept = 1'b0;
    check("to_count1", fifo_count, 1);
    repeat (6) tick();
    check("to_abort_early", seq_abort, 0);
    tick();
    check("to_abort", seq_abort, 1);
    check("to_pre_flush", fifo_count, 1);
    tick();
    check("to_abort_pulse", seq_abort, 0);
    check("to_flushed", fifo_count, 0);

    // bounce: no push while toggling, one push once stable
    accept = 1'b1; key_code = 4'h3;
    base = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      key_down = (i % 2 == 0);
      tick();
    end
    check("bn_quiet", rd_cnt - base, 0);
    key_down = 1'b1;
    repeat (10) tick();
    check("bn_one", rd_cnt - base, 1);
    check("bn_digit", last_digit, 4'h3);
    key_down = 1'b0;
    repeat (20) tick();

    // overflow: fifth digit dropped, then drain in order
    accept = 1'b0;
    for (int i = 1; i <= 5; i++) press(DW'(i));
    check("ov_count", fifo_count, 4);
    check("ov_flag", overflow, 1);
    accept = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check("ov_read", read, 1);
      check("ov_digit", digit, i);
      tick();
    end
    check("ov_empty", fifo_count, 0);
    check("ov_idle", read, 0);

    // reset mid PRESS_WAIT with timer running
    key_code = 4'h6; key_down = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("mr_read", read, 0);
    check("mr_digit", digit, 0);
    check("mr_abort", seq_abort, 0);
    check("mr_ovf", overflow, 0);
    check("mr_count", fifo_count, 0);
    tick();
    reset = 1'b0;
    base = rd_cnt;
    repeat (6) tick();
    check("mr_early", read, 0);
    tick();
    check("mr_read2", read, 1);
    check("mr_digit2", digit, 4'h6);
    tick();
    check("mr_pulse", read, 0);
    repeat (10) tick();
    check("mr_once", rd_cnt - base, 1);
    key_down = 1'b0;
    repeat (20) tick();

    // full FIFO: push and pop in the same cycle
    accept = 1'b0;
    for (int i = 1; i <= 4; i++) press(DW'(i));
    check("fp_full", fifo_count, 4);
    key_code = 4'h5; key_down = 1'b1;
    repeat (6) tick();
    accept = 1'b1;
    #1;
    check("fp_read", read, 1);
    check("fp_head", digit, 4'h1);
    tick();
    check("fp_count", fifo_count, 4);
    check("fp_ovf", overflow, 0);
    for (int d = 2; d <= 5; d++) begin
      check("fp_read_n", read, 1);
      check("fp_digit", digit, d);
      tick();
    end
    check("fp_empty", fifo_count, 0);
    key_down = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
